// File: rtl/mulu_seq_ctrl.sv
// Sequential unsigned shift-add multiplier controller, one step per clock.
// Optional early termination when the multiplier runs out: MULU_EARLY_TERM_EN.
module mulu_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               abort,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] c
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [1:0]         state;
  logic [2*WIDTH-1:0] x;
  logic [WIDTH-1:0]   y;
  logic [2*WIDTH-1:0] z;
  logic [CNT_W-1:0]   cnt;

  logic [2*WIDTH-1:0] z_nxt;
  logic               fin;

  // Accumulator after this step and the run-exit condition.
  always_comb begin
    z_nxt = z + (y[0] ? x : '0);
`ifdef MULU_EARLY_TERM_EN
    fin   = (cnt == LAST) || (y[WIDTH-1:1] == '0);
`else
    fin   = (cnt == LAST);
`endif
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Control state, datapath registers and product register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
      z     <= '0;
      cnt   <= '0;
      c     <= '0;
    end else if (abort) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x     <= {{WIDTH{1'b0}}, a};
            y     <= b;
            z     <= '0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          z   <= z_nxt;
          x   <= x << 1;
          y   <= y >> 1;
          cnt <= cnt + 1'b1;
          if (fin) begin
            c     <= z_nxt;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mulu_seq_ctrl.sv
// Directed self-checking bench for mulu_seq_ctrl (WIDTH=8).
// Expectations follow the early-termination macro when it is defined.
module tb_mulu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        abort = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] c;

  int n_tests = 0;
  int n_fail  = 0;

  mulu_seq_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready),
    .c(c)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int lat_exp(input logic [7:0] bb);
`ifdef MULU_EARLY_TERM_EN
    int l;
    l = 1;
    for (int i = 0; i < 8; i++)
      if (bb[i]) l = i + 1;
    return l;
`else
    return 8;
`endif
  endfunction

  task automatic start(input logic [7:0] aa, input logic [7:0] bb);
    chk("accept_ready", {31'd0, in_ready}, 32'd1);
    a = aa;
    b = bb;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    @(posedge clk);
    #1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) chk("done_timeout", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("hs_out_valid", {31'd0, out_valid}, 32'd0);
    chk("hs_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    logic [7:0] ra, rb;
    logic [15:0] c_prev;

    // Reset state.
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_c", {16'd0, c}, 32'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // Max operands.
    start(8'hFF, 8'hFF);
    chk("run_in_ready", {31'd0, in_ready}, 32'd0);
    wait_done(lat);
    chk("ff_lat", lat, 8);
    chk("ff_c", {16'd0, c}, 32'hFE01);
    chk("done_in_ready", {31'd0, in_ready}, 32'd0);
    handshake();

    // Output stall holds c and out_valid.
    start(8'd13, 8'd11);
    wait_done(lat);
    chk("13x11_lat", lat, lat_exp(8'd11));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_c", {16'd0, c}, 32'd143);
    end
    handshake();

    // Abort three edges after accept.
    start(8'd200, 8'd3);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #1;
`ifdef MULU_EARLY_TERM_EN
      chk("abort_pre_valid", {31'd0, out_valid}, {31'd0, i >= 2});
`else
      chk("abort_pre_valid", {31'd0, out_valid}, 32'd0);
`endif
    end
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
`ifdef MULU_EARLY_TERM_EN
    chk("abort_c", {16'd0, c}, 32'd600);
`else
    chk("abort_c", {16'd0, c}, 32'd143);
`endif
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("abort_stay_idle", {31'd0, out_valid}, 32'd0);
    end

    // Abort beats a simultaneous accept.
    a = 8'd5;
    b = 8'd5;
    in_valid = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    abort = 1'b0;
    chk("abort_vs_accept", {31'd0, in_ready}, 32'd1);

    // Zero multiplier and top-bit-only multiplier.
    start(8'd7, 8'd0);
    wait_done(lat);
    chk("b0_lat", lat, lat_exp(8'd0));
    chk("b0_c", {16'd0, c}, 32'd0);
    handshake();
    start(8'd7, 8'h80);
    wait_done(lat);
    chk("b80_lat", lat, 8);
    chk("b80_c", {16'd0, c}, 32'd896);
    handshake();

    // Abort while DONE wins over out_ready; c is kept.
    start(8'd9, 8'd9);
    wait_done(lat);
    abort = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    out_ready = 1'b0;
    chk("abort_done_idle", {31'd0, in_ready}, 32'd1);
    chk("abort_done_c", {16'd0, c}, 32'd81);

    // Random back-to-back with stalls and junk in_valid during DONE.
    for (int n = 0; n < 50; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      start(ra, rb);
      wait_done(lat);
      chk("rnd_lat", lat, lat_exp(rb));
      chk("rnd_c", {16'd0, c}, {16'd0, 16'(ra) * 16'(rb)});
      c_prev = c;
      a = ~ra;
      b = ~rb;
      in_valid = 1'b1;
      for (int s = $urandom_range(0, 3); s > 0; s--) begin
        @(posedge clk);
        #1;
        chk("rnd_no_accept", {31'd0, in_ready}, 32'd0);
        chk("rnd_hold_c", {16'd0, c}, {16'd0, c_prev});
      end
      handshake();
    end

    // Asynchronous reset mid-operation.
    start(8'd50, 8'd50);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_c", {16'd0, c}, 32'd0);
    chk("async_rst_ready", {31'd0, in_ready}, 32'd1);
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
